// File: rtl/cu_wb_pipe_if.sv
// rtl/cu_wb_pipe_if.sv - decode/writeback bus for cu_wb_pipe (CU_WB_ILLEGAL_EN adds illegal_o)
interface cu_wb_pipe_if #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5
);
  logic                         in_valid;
  logic [10:0]                  control_signal;
  logic [REG_AW-1:0]            rd_addr_i;
  logic                         stall;
  logic                         flush;
  logic [1:0]                   wb_sel;
  logic                         rd_wren;
  logic [REG_AW-1:0]            rd_addr_o;
  logic                         wb_valid;
  logic [NUM_STAGES-1:0]        stage_wren;
  logic [NUM_STAGES-1:0]        stage_is_load;
  logic [NUM_STAGES*REG_AW-1:0] stage_rd;
`ifdef CU_WB_ILLEGAL_EN
  logic                         illegal_o;
`endif

  modport master (
    output in_valid, control_signal, rd_addr_i, stall, flush,
`ifdef CU_WB_ILLEGAL_EN
    input  illegal_o,
`endif
    input  wb_sel, rd_wren, rd_addr_o, wb_valid, stage_wren, stage_is_load, stage_rd
  );

  modport slave (
    input  in_valid, control_signal, rd_addr_i, stall, flush,
`ifdef CU_WB_ILLEGAL_EN
    output illegal_o,
`endif
    output wb_sel, rd_wren, rd_addr_o, wb_valid, stage_wren, stage_is_load, stage_rd
  );
endinterface

// File: rtl/cu_wb_pipe.sv
// rtl/cu_wb_pipe.sv - RV32I writeback-control pipeline (CU_WB_ILLEGAL_EN adds illegal_o)
module cu_wb_pipe #(
  parameter int NUM_STAGES  = 3,
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  cu_wb_pipe_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              wren;
    logic              load;
`ifdef CU_WB_ILLEGAL_EN
    logic              illegal;
`endif
    logic [1:0]        sel;
    logic [REG_AW-1:0] rd;
  } stage_t;

  stage_t                       w_dec;
  logic                         w_illegal;
  logic [4:0]                   w_opcode;
  logic [2:0]                   w_funct3;
  logic                         w_bit30;
  logic                         w_unused_cmp;
  logic [NUM_STAGES-1:0]        w_stage_wren;
  logic [NUM_STAGES-1:0]        w_stage_load;
  logic [NUM_STAGES*REG_AW-1:0] w_stage_rd;
  logic                         w_last_valid;
  logic [1:0]                   w_last_sel;
  logic [REG_AW-1:0]            w_last_rd;
`ifdef CU_WB_ILLEGAL_EN
  logic                         w_last_illegal;
`endif

  assign w_opcode     = bus.control_signal[6:2];
  assign w_funct3     = bus.control_signal[9:7];
  assign w_bit30      = bus.control_signal[10];
  // Branch compare flags travel on the same word but play no part in writeback.
  assign w_unused_cmp = ^bus.control_signal[1:0];

  // Decode the incoming control word into a stage record.
  always_comb begin
    w_dec       = '0;
    w_illegal   = 1'b0;
    w_dec.valid = bus.in_valid;
    w_dec.rd    = bus.rd_addr_i;
    case (w_opcode)
      5'b01100: begin
        w_dec.wren = 1'b1;
        w_illegal  = w_bit30 && (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
      end
      5'b00100: begin
        w_dec.wren = 1'b1;
        w_illegal  = w_bit30 && (w_funct3 == 3'b001);
      end
      5'b00000: begin
        w_dec.wren = 1'b1;
        w_dec.load = 1'b1;
        w_dec.sel  = 2'b01;
        w_illegal  = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      5'b11011, 5'b11001: begin
        w_dec.wren = 1'b1;
        w_dec.sel  = 2'b10;
      end
      5'b00101: w_dec.wren = 1'b1;
      5'b01101: begin
        w_dec.wren = 1'b1;
        w_dec.sel  = 2'b11;
      end
      5'b01000, 5'b11000: w_dec.wren = 1'b0;
      default: w_illegal = 1'b1;
    endcase
    // An illegal word behaves like a no-write ALU op so nothing downstream acts on it.
    if (w_illegal) begin
      w_dec.wren = 1'b0;
      w_dec.load = 1'b0;
      w_dec.sel  = 2'b00;
    end
`ifdef CU_WB_ILLEGAL_EN
    w_dec.illegal = w_illegal;
`endif
    if (bus.rd_addr_i == '0) w_dec.wren = 1'b0;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_STAGES; g++) begin : g_stage
      localparam bit FLUSHED = (g < FLUSH_DEPTH);
      stage_t r_q;
      stage_t w_src;

      if (g == 0) begin : g_head
        assign w_src = w_dec;
      end else begin : g_tail
        assign w_src = g_stage[g-1].r_q;
      end

      // Stage register: reset clears, stall holds, flush then kills the youngest stages.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else begin
          if (!bus.stall) r_q <= w_src;
          if (bus.flush && FLUSHED) r_q.valid <= 1'b0;
        end
      end

      assign w_stage_wren[g]                = r_q.valid & r_q.wren;
      assign w_stage_load[g]                = r_q.valid & r_q.load;
      assign w_stage_rd[g*REG_AW +: REG_AW] = r_q.rd;

      if (g == NUM_STAGES - 1) begin : g_last
        assign w_last_valid   = r_q.valid;
        assign w_last_sel     = r_q.sel;
        assign w_last_rd      = r_q.rd;
`ifdef CU_WB_ILLEGAL_EN
        assign w_last_illegal = r_q.illegal;
`endif
      end
    end
  endgenerate

  assign bus.wb_valid      = w_last_valid;
  assign bus.rd_wren       = w_stage_wren[NUM_STAGES-1];
  assign bus.wb_sel        = w_last_valid ? w_last_sel : 2'b00;
  assign bus.rd_addr_o     = w_last_valid ? w_last_rd : '0;
  assign bus.stage_wren    = w_stage_wren;
  assign bus.stage_is_load = w_stage_load;
  assign bus.stage_rd      = w_stage_rd;
`ifdef CU_WB_ILLEGAL_EN
  assign bus.illegal_o     = w_last_valid & w_last_illegal;
`endif

endmodule

// File: tb/tb_cu_wb_pipe.sv
// tb/tb_cu_wb_pipe.sv - self-checking bench for cu_wb_pipe (CU_WB_ILLEGAL_EN enables illegal checks)
module tb_cu_wb_pipe;
  localparam int NS = 3;
  localparam int AW = 5;
  localparam int FD = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cu_wb_pipe_if #(.NUM_STAGES(NS), .REG_AW(AW)) bus();
  cu_wb_pipe #(.NUM_STAGES(NS), .REG_AW(AW), .FLUSH_DEPTH(FD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    bit           w;
    bit           l;
    bit           il;
    bit [1:0]     s;
    bit [AW-1:0]  rd;
  } slot_t;

  slot_t m [NS];

  typedef struct {
    string        name;
    logic [10:0]  ctrl;
    logic [AW-1:0] rd;
    logic [1:0]   sel;
    bit           wren;
    bit           load;
  } vec_t;

  vec_t vt [$];

  function automatic slot_t ref_decode(bit v, logic [10:0] c, logic [AW-1:0] rd);
    slot_t    s;
    bit [4:0] op  = c[6:2];
    bit [2:0] f3  = c[9:7];
    bit       alt = c[10];
    bit       ok  = 1'b1;
    bit       wr  = 1'b0;
    bit       ld  = 1'b0;
    bit [1:0] sel = 2'b00;
    if (op == 5'b01100) begin wr = 1; ok = !alt || f3 == 3'd0 || f3 == 3'd5; end
    else if (op == 5'b00100) begin wr = 1; ok = !(alt && f3 == 3'd1); end
    else if (op == 5'b00000) begin wr = 1; sel = 2'd1; ld = 1; ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
    else if (op == 5'b11011 || op == 5'b11001) begin wr = 1; sel = 2'd2; end
    else if (op == 5'b00101) wr = 1;
    else if (op == 5'b01101) begin wr = 1; sel = 2'd3; end
    else if (op == 5'b01000 || op == 5'b11000) wr = 0;
    else ok = 0;
    if (!ok) begin wr = 0; sel = 0; ld = 0; end
    s.v = v; s.w = wr && (rd != 0); s.l = ld; s.il = !ok; s.s = sel; s.rd = rd;
    return s;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int k = 0; k < NS; k++) m[k] = '{default: 0};
    end else begin
      if (!bus.stall) begin
        for (int k = NS - 1; k > 0; k--) m[k] = m[k-1];
        m[0] = ref_decode(bus.in_valid, bus.control_signal, bus.rd_addr_i);
      end
      if (bus.flush) for (int k = 0; k < FD; k++) m[k].v = 0;
    end
  endtask

  function automatic logic [63:0] dut_bundle();
    logic [63:0] b;
    b = 64'({bus.wb_valid, bus.wb_sel, bus.rd_wren, bus.rd_addr_o,
             bus.stage_wren, bus.stage_is_load, bus.stage_rd});
`ifdef CU_WB_ILLEGAL_EN
    b[48] = bus.illegal_o;
`endif
    return b;
  endfunction

  function automatic logic [63:0] model_bundle();
    logic [63:0]         b;
    logic [NS-1:0]       sw;
    logic [NS-1:0]       sl;
    logic [NS*AW-1:0]    srd;
    slot_t               last;
    last = m[NS-1];
    for (int k = 0; k < NS; k++) begin
      sw[k] = m[k].v & m[k].w;
      sl[k] = m[k].v & m[k].l;
      srd[k*AW +: AW] = m[k].rd;
    end
    b = 64'({last.v, last.v ? last.s : 2'b00, last.v & last.w,
             last.v ? last.rd : 5'd0, sw, sl, srd});
`ifdef CU_WB_ILLEGAL_EN
    b[48] = last.v & last.il;
`endif
    return b;
  endfunction

  function automatic logic [8:0] wb4();
    return {bus.wb_valid, bus.wb_sel, bus.rd_wren, bus.rd_addr_o};
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(bit v, logic [10:0] c, logic [AW-1:0] rd, bit st, bit fl);
    bus.in_valid       = v;
    bus.control_signal = c;
    bus.rd_addr_i      = rd;
    bus.stall          = st;
    bus.flush          = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(int n);
    drive(0, 11'h000, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [10:0] codes [16];
    for (int k = 0; k < NS; k++) m[k] = '{default: 0};
    drive(0, 11'h000, 0, 0, 0);

    vt.push_back('{"add",    11'h030, 5'd5,  2'b00, 1, 0});
    vt.push_back('{"sub",    11'h430, 5'd6,  2'b00, 1, 0});
    vt.push_back('{"sll_b30",11'h4B0, 5'd6,  2'b00, 0, 0});
    vt.push_back('{"sra",    11'h6B0, 5'd8,  2'b00, 1, 0});
    vt.push_back('{"addi",   11'h010, 5'd10, 2'b00, 1, 0});
    vt.push_back('{"addi_x0",11'h010, 5'd0,  2'b00, 0, 0});
    vt.push_back('{"slli_b30",11'h490,5'd11, 2'b00, 0, 0});
    vt.push_back('{"srai",   11'h690, 5'd12, 2'b00, 1, 0});
    vt.push_back('{"lw",     11'h100, 5'd13, 2'b01, 1, 1});
    vt.push_back('{"ld_bad", 11'h180, 5'd14, 2'b00, 0, 0});
    vt.push_back('{"lbu",    11'h200, 5'd15, 2'b01, 1, 1});
    vt.push_back('{"jal",    11'h06C, 5'd1,  2'b10, 1, 0});
    vt.push_back('{"jalr",   11'h064, 5'd16, 2'b10, 1, 0});
    vt.push_back('{"auipc",  11'h014, 5'd17, 2'b00, 1, 0});
    vt.push_back('{"lui",    11'h034, 5'd18, 2'b11, 1, 0});
    vt.push_back('{"sw",     11'h120, 5'd19, 2'b00, 0, 0});
    vt.push_back('{"beq",    11'h060, 5'd20, 2'b00, 0, 0});
    vt.push_back('{"opc11111",11'h07C,5'd21, 2'b00, 0, 0});

    // Reset for two cycles, then the first ADD x5 must surface after three edges.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_state", dut_bundle(), 64'd0);
    drive(1, 11'h030, 5'd5, 0, 0);
    tick();
    drive(0, 11'h000, 0, 0, 0);
    tick();
    chk("add_not_yet", 64'(wb4()), 64'd0);
    tick();
    chk("add_x5_wb", 64'(wb4()), 64'({1'b1, 2'b00, 1'b1, 5'd5}));

    // One instruction per vector through an otherwise empty pipe.
    foreach (vt[i]) begin
      idle(NS);
      drive(1, vt[i].ctrl, vt[i].rd, 0, 0);
      tick();
      chk({vt[i].name, "_load0"}, 64'(bus.stage_is_load[0]), 64'(vt[i].load));
      drive(0, 11'h000, 0, 0, 0);
      for (int k = 1; k < NS; k++) tick();
      chk({vt[i].name, "_wb"}, 64'(wb4()),
          64'({1'b1, vt[i].sel, vt[i].wren, vt[i].rd}));
    end

    // LW x7, JAL x1, SW back-to-back.
    idle(NS);
    drive(1, 11'h100, 5'd7, 0, 0);
    tick();
    chk("b2b_load_cap", 64'(bus.stage_is_load), 64'(3'b001));
    drive(1, 11'h06C, 5'd1, 0, 0);
    tick();
    chk("b2b_load_mv", 64'(bus.stage_is_load), 64'(3'b010));
    drive(1, 11'h120, 5'd2, 0, 0);
    tick();
    chk("b2b_lw", 64'(wb4()), 64'({1'b1, 2'b01, 1'b1, 5'd7}));
    drive(0, 11'h000, 0, 0, 0);
    tick();
    chk("b2b_jal", 64'(wb4()), 64'({1'b1, 2'b10, 1'b1, 5'd1}));
    tick();
    chk("b2b_sw", 64'(wb4()), 64'({1'b1, 2'b00, 1'b0, 5'd2}));

    // LUI x3 stalled two cycles in stage 1.
    idle(NS);
    drive(1, 11'h034, 5'd3, 0, 0);
    tick();
    drive(0, 11'h000, 0, 0, 0);
    tick();
    drive(0, 11'h000, 0, 1, 0);
    tick();
    chk("stall_out1", 64'(wb4()), 64'd0);
    tick();
    chk("stall_out2", 64'(wb4()), 64'd0);
    chk("stall_hold", 64'(bus.stage_wren), 64'(3'b010));
    drive(0, 11'h000, 0, 0, 0);
    tick();
    chk("stall_lui", 64'(wb4()), 64'({1'b1, 2'b11, 1'b1, 5'd3}));

    // Flush on the edge that captures LW x9; the older ADD retires.
    idle(NS);
    drive(1, 11'h030, 5'd5, 0, 0);
    tick();
    drive(1, 11'h100, 5'd9, 0, 1);
    tick();
    chk("flush_kill", 64'(bus.stage_is_load), 64'd0);
    drive(0, 11'h000, 0, 0, 0);
    tick();
    chk("flush_older", 64'(wb4()), 64'({1'b1, 2'b00, 1'b1, 5'd5}));
    tick();
    chk("flush_gone", 64'(wb4()), 64'd0);

`ifdef CU_WB_ILLEGAL_EN
    idle(NS);
    drive(1, 11'h07C, 5'd4, 0, 0);
    tick();
    drive(0, 11'h000, 0, 0, 0);
    tick();
    tick();
    chk("ill_wb", 64'({bus.illegal_o, bus.rd_wren}), 64'(2'b10));
    idle(NS);
    drive(1, 11'h07C, 5'd4, 0, 0);
    tick();
    drive(0, 11'h000, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ill_rst0", 64'(bus.illegal_o), 64'd0);
    tick();
    tick();
    chk("ill_rst1", 64'(bus.illegal_o), 64'd0);
`endif

    // Randomised traffic against the reference model.
    foreach (vt[i]) if (i < 16) codes[i] = vt[i].ctrl;
    for (int n = 0; n < 600; n++) begin
      logic [10:0] c;
      logic [AW-1:0] rd;
      c  = ($urandom_range(0, 1) == 0) ? codes[$urandom_range(0, 15)] : 11'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      drive($urandom_range(0, 3) != 0, c, rd,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
      chk("rand", dut_bundle(), model_bundle());
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
